// File: rtl/icache_port_arb_pkg.sv
// Shared types and widths for the icache request-port arbiter.
// Queue entries record the owner of each accepted request and whether it was cancelled.
package icache_port_arb_pkg;

  localparam int ICACHE_OP_W   = 5;
  localparam int ICACHE_DATA_W = 64;

  typedef struct packed {
    logic is_cacop;
    logic cancel;
  } oq_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_F = 2'd1,
    HOLD_C = 2'd2
  } grant_state_e;

endpackage

// File: rtl/icache_port_oq.sv
// In-order outstanding queue of accepted icache requests.
// Flush marks every stored fetch entry cancelled; cacop entries are untouched.
module icache_port_oq
  import icache_port_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  oq_entry_t        push_entry,
  input  logic             pop,
  input  logic             flush,
  output oq_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             push_err
);

  localparam int SLOTS = 2 ** CNT_W;

  oq_entry_t        mem_q [SLOTS];
  logic [CNT_W-1:0] head_q;
  logic [CNT_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;
  logic             push_ok;

  function automatic logic [CNT_W-1:0] nxt(
    input logic [CNT_W-1:0] p
  );
    return (p == CNT_W'(DEPTH - 1)) ? '0 : p + CNT_W'(1);
  endfunction

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign head     = mem_q[head_q];
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign push_err = push & full & ~pop_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (!mem_q[i].is_cacop) begin
            mem_q[i].cancel <= 1'b1;
          end
        end
      end
      // A push in the flush cycle already carries its own cancel bit
      if (push_ok) begin
        mem_q[tail_q] <= push_entry;
        tail_q        <= nxt(tail_q);
      end
      if (pop_ok) begin
        head_q <= nxt(head_q);
      end
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/icache_port_arb.sv
// Arbitrates the icache request port between fetch and cacop requesters.
// Routes in-order responses to their owner and drops cancelled fetches.
module icache_port_arb
  import icache_port_arb_pkg::*;
#(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     fetch_req_i,
  input  logic [31:0]              fetch_addr_i,
  output logic                     fetch_addr_ok_o,
  output logic                     fetch_data_ok_o,
  output logic [ICACHE_DATA_W-1:0] fetch_rdata_o,
  input  logic                     cacop_req_i,
  input  logic [ICACHE_OP_W-1:0]   cacop_op_i,
  input  logic [31:0]              cacop_addr_i,
  output logic                     cacop_addr_ok_o,
  output logic                     cacop_done_o,
  output logic                     icache_req_o,
  output logic                     icache_is_cacop_o,
  output logic [ICACHE_OP_W-1:0]   icache_op_o,
  output logic [31:0]              icache_addr_o,
  input  logic                     icache_addr_ok_i,
  input  logic                     icache_data_ok_i,
  input  logic [ICACHE_DATA_W-1:0] icache_rdata_i,
  output logic [CNT_W-1:0]         out_num_o,
  output logic                     error_o
);

  grant_state_e           state_q, state_d;
  logic [31:0]            hold_addr_q, hold_addr_d;
  logic [ICACHE_OP_W-1:0] hold_op_q, hold_op_d;
  logic                   hold_cancel_q, hold_cancel_d;
  logic                   error_q;

  logic             pick_c, pick_f;
  logic             own_f, own_c;
  logic             accept;
  logic             cacop_pend;
  logic             push, pop;
  oq_entry_t        push_entry;
  oq_entry_t        head;
  logic [CNT_W-1:0] out_num;
  logic             full, empty, push_err;
  logic             head_live;

  icache_port_oq #(
    .DEPTH (MAX_OUT),
    .CNT_W (CNT_W)
  ) u_oq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush_i),
    .head       (head),
    .count      (out_num),
    .full       (full),
    .empty      (empty),
    .push_err   (push_err)
  );

  // A cacop only enters an empty queue and blocks fetches, so it is always the head
  assign cacop_pend = ~empty & head.is_cacop;

  always_comb begin
    pick_c = cacop_req_i & (out_num == '0);
    pick_f = ~pick_c & fetch_req_i & ~cacop_pend
           & (out_num < CNT_W'(MAX_OUT));
    state_d           = state_q;
    hold_addr_d       = hold_addr_q;
    hold_op_d         = hold_op_q;
    hold_cancel_d     = hold_cancel_q;
    icache_req_o      = 1'b0;
    icache_is_cacop_o = 1'b0;
    icache_op_o       = '0;
    icache_addr_o     = '0;
    own_f             = 1'b0;
    own_c             = 1'b0;
    unique case (state_q)
      IDLE: begin
        own_c             = pick_c;
        own_f             = pick_f;
        icache_req_o      = pick_c | pick_f;
        icache_is_cacop_o = pick_c;
        unique case (1'b1)
          pick_c: begin
            icache_op_o   = cacop_op_i;
            icache_addr_o = cacop_addr_i;
          end
          pick_f: icache_addr_o = fetch_addr_i;
          default: ;
        endcase
        if (icache_req_o && !icache_addr_ok_i) begin
          hold_addr_d   = icache_addr_o;
          hold_op_d     = icache_op_o;
          hold_cancel_d = pick_f & flush_i;
          state_d       = pick_c ? HOLD_C : HOLD_F;
        end
      end
      HOLD_F: begin
        own_f         = 1'b1;
        icache_req_o  = 1'b1;
        icache_addr_o = hold_addr_q;
        hold_cancel_d = hold_cancel_q | flush_i;
        if (icache_addr_ok_i) begin
          hold_cancel_d = 1'b0;
          state_d       = IDLE;
        end
      end
      HOLD_C: begin
        own_c             = 1'b1;
        icache_req_o      = 1'b1;
        icache_is_cacop_o = 1'b1;
        icache_op_o       = hold_op_q;
        icache_addr_o     = hold_addr_q;
        if (icache_addr_ok_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept          = icache_addr_ok_i & icache_req_o;
  assign fetch_addr_ok_o = accept & own_f & ~hold_cancel_q & ~flush_i;
  assign cacop_addr_ok_o = accept & own_c;

  assign push                = accept;
  assign push_entry.is_cacop = own_c;
  assign push_entry.cancel   = own_f & (hold_cancel_q | flush_i);

  // Flush wins over a response arriving in the same cycle
  assign pop             = icache_data_ok_i & ~empty;
  assign head_live       = pop & ~head.is_cacop & ~head.cancel & ~flush_i;
  assign fetch_data_ok_o = head_live;
  assign fetch_rdata_o   = head_live ? icache_rdata_i : '0;
  assign cacop_done_o    = pop & head.is_cacop;

  assign out_num_o = out_num;
  assign error_o   = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hold_addr_q   <= '0;
      hold_op_q     <= '0;
      hold_cancel_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_addr_q   <= hold_addr_d;
      hold_op_q     <= hold_op_d;
      hold_cancel_q <= hold_cancel_d;
      if ((icache_data_ok_i & empty) |
          (icache_addr_ok_i & ~icache_req_o) |
          push_err) begin
        error_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_port_arb.sv
// Directed bench for icache_port_arb: inputs change at negedge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_icache_port_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_addr_ok;
  logic        fetch_data_ok;
  logic [63:0] fetch_rdata;
  logic        cacop_req;
  logic [4:0]  cacop_op;
  logic [31:0] cacop_addr;
  logic        cacop_addr_ok;
  logic        cacop_done;
  logic        ic_req;
  logic        ic_is_cacop;
  logic [4:0]  ic_op;
  logic [31:0] ic_addr;
  logic        ic_addr_ok;
  logic        ic_data_ok;
  logic [63:0] ic_rdata;
  logic [1:0]  out_num;
  logic        error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  icache_port_arb #(.MAX_OUT(2), .CNT_W(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .flush_i           (flush),
    .fetch_req_i       (fetch_req),
    .fetch_addr_i      (fetch_addr),
    .fetch_addr_ok_o   (fetch_addr_ok),
    .fetch_data_ok_o   (fetch_data_ok),
    .fetch_rdata_o     (fetch_rdata),
    .cacop_req_i       (cacop_req),
    .cacop_op_i        (cacop_op),
    .cacop_addr_i      (cacop_addr),
    .cacop_addr_ok_o   (cacop_addr_ok),
    .cacop_done_o      (cacop_done),
    .icache_req_o      (ic_req),
    .icache_is_cacop_o (ic_is_cacop),
    .icache_op_o       (ic_op),
    .icache_addr_o     (ic_addr),
    .icache_addr_ok_i  (ic_addr_ok),
    .icache_data_ok_i  (ic_data_ok),
    .icache_rdata_i    (ic_rdata),
    .out_num_o         (out_num),
    .error_o           (error)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    flush = 0; fetch_req = 0; fetch_addr = '0;
    cacop_req = 0; cacop_op = '0; cacop_addr = '0;
    ic_addr_ok = 0; ic_data_ok = 0; ic_rdata = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle_in();
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    #12;
    chk("rst_req", ic_req, 0);
    chk("rst_num", out_num, 0);
    chk("rst_err", error, 0);
    chk("rst_aok", fetch_addr_ok, 0);
    chk("rst_dok", fetch_data_ok, 0);
    @(negedge clk);
    rst_n = 1;

    // basic fetch, zero-latency response
    cyc(); fetch_req = 1; fetch_addr = 32'h1c000000; ic_addr_ok = 1; settle();
    chk("t1_req", ic_req, 1);
    chk("t1_addr", ic_addr, 32'h1c000000);
    chk("t1_isc", ic_is_cacop, 0);
    chk("t1_aok", fetch_addr_ok, 1);
    cyc(); settle();
    chk("t1_num1", out_num, 1);
    chk("t1_aok0", fetch_addr_ok, 0);
    cyc(); ic_data_ok = 1; ic_rdata = 64'h0280000102800002; settle();
    chk("t1_dok", fetch_data_ok, 1);
    chk("t1_rdata", fetch_rdata, 64'h0280000102800002);
    cyc(); settle();
    chk("t1_num0", out_num, 0);
    chk("t1_dok0", fetch_data_ok, 0);

    // held request keeps first address
    cyc(); fetch_req = 1; fetch_addr = 32'h1c000010; settle();
    chk("t2_a0", ic_addr, 32'h1c000010);
    cyc(); fetch_req = 1; fetch_addr = 32'h1c000020; settle();
    chk("t2_a1", ic_addr, 32'h1c000010);
    chk("t2_r1", ic_req, 1);
    cyc(); fetch_req = 1; fetch_addr = 32'h1c000030; settle();
    chk("t2_a2", ic_addr, 32'h1c000010);
    cyc(); fetch_addr = 32'h1c000040; ic_addr_ok = 1; settle();
    chk("t2_a3", ic_addr, 32'h1c000010);
    chk("t2_aok", fetch_addr_ok, 1);
    cyc(); settle();
    chk("t2_num", out_num, 1);
    cyc(); ic_data_ok = 1; ic_rdata = 64'h11; settle();
    chk("t2_dok", fetch_data_ok, 1);
    cyc(); settle();
    chk("t2_num0", out_num, 0);

    // two outstanding, full blocks, flush drops both
    cyc(); fetch_req = 1; fetch_addr = 32'h100; ic_addr_ok = 1; settle();
    chk("t3_aok0", fetch_addr_ok, 1);
    cyc(); fetch_req = 1; fetch_addr = 32'h108; ic_addr_ok = 1; settle();
    chk("t3_num1", out_num, 1);
    chk("t3_aok1", fetch_addr_ok, 1);
    cyc(); fetch_req = 1; fetch_addr = 32'h110; settle();
    chk("t3_num2", out_num, 2);
    chk("t3_blk", ic_req, 0);
    cyc(); flush = 1; settle();
    chk("t3_fl", fetch_data_ok, 0);
    cyc(); ic_data_ok = 1; settle();
    chk("t3_d0", fetch_data_ok, 0);
    cyc(); ic_data_ok = 1; settle();
    chk("t3_d1", fetch_data_ok, 0);
    chk("t3_n1", out_num, 1);
    cyc(); settle();
    chk("t3_n0", out_num, 0);
    chk("t3_err", error, 0);

    // cacop waits for outstanding fetch, then blocks fetches
    cyc(); fetch_req = 1; fetch_addr = 32'h200; ic_addr_ok = 1; settle();
    chk("t4_faok", fetch_addr_ok, 1);
    cyc(); cacop_req = 1; cacop_op = 5'h09; cacop_addr = 32'h300; settle();
    chk("t4_wait", ic_req, 0);
    cyc(); cacop_req = 1; cacop_op = 5'h09; cacop_addr = 32'h300;
    ic_data_ok = 1; ic_rdata = 64'h22; settle();
    chk("t4_fdok", fetch_data_ok, 1);
    chk("t4_wait2", ic_req, 0);
    cyc(); cacop_req = 1; cacop_op = 5'h09; cacop_addr = 32'h300;
    ic_addr_ok = 1; settle();
    chk("t4_creq", ic_req, 1);
    chk("t4_isc", ic_is_cacop, 1);
    chk("t4_op", ic_op, 5'h09);
    chk("t4_addr", ic_addr, 32'h300);
    chk("t4_caok", cacop_addr_ok, 1);
    cyc(); fetch_req = 1; fetch_addr = 32'h208; settle();
    chk("t4_fblk", ic_req, 0);
    cyc(); ic_data_ok = 1; settle();
    chk("t4_done", cacop_done, 1);
    chk("t4_nofd", fetch_data_ok, 0);
    cyc(); settle();
    chk("t4_n0", out_num, 0);

    // flush while holding a fetch
    cyc(); fetch_req = 1; fetch_addr = 32'h400; settle();
    chk("t5_req", ic_req, 1);
    cyc(); flush = 1; settle();
    chk("t5_hold", ic_addr, 32'h400);
    cyc(); ic_addr_ok = 1; settle();
    chk("t5_aok", fetch_addr_ok, 0);
    cyc(); settle();
    chk("t5_num", out_num, 1);
    cyc(); ic_data_ok = 1; ic_rdata = 64'h33; settle();
    chk("t5_dok", fetch_data_ok, 0);
    cyc(); settle();
    chk("t5_n0", out_num, 0);

    // fetch accepted during flush, then flush beats a live response
    cyc(); fetch_req = 1; fetch_addr = 32'h500; ic_addr_ok = 1;
    flush = 1; settle();
    chk("t6_aok", fetch_addr_ok, 0);
    cyc(); fetch_req = 1; fetch_addr = 32'h508; ic_addr_ok = 1; settle();
    chk("t6_aok1", fetch_addr_ok, 1);
    cyc(); ic_data_ok = 1; settle();
    chk("t6_drop", fetch_data_ok, 0);
    cyc(); ic_data_ok = 1; flush = 1; settle();
    chk("t6_flwin", fetch_data_ok, 0);
    cyc(); settle();
    chk("t6_n0", out_num, 0);
    chk("t6_err", error, 0);

    // spurious data_ok sets sticky error
    cyc(); ic_data_ok = 1; settle();
    chk("t7_err0", error, 0);
    cyc(); settle();
    chk("t7_err1", error, 1);
    cyc(); cyc(); settle();
    chk("t7_stk", error, 1);
    rst_n = 0; settle();
    chk("t7_rst", error, 0);
    cyc(); rst_n = 1;

    // addr_ok without a request
    cyc(); ic_addr_ok = 1; settle();
    chk("t8_err0", error, 0);
    cyc(); settle();
    chk("t8_err1", error, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_port_arb.md
Name: icache_port_arb

Overview:
- Schedules the single instruction-cache request port between two requesters: the pre-IF fetch request and the cacop/ibar maintenance request.
- Tracks every accepted request in order in an outstanding queue and routes each icache data_ok/rdata to its owner.
- Drops responses belonging to fetches that were cancelled by a pipeline flush.
- Sits between the pre-IF/IF-T stages and the icache; replaces the ad-hoc per-stage data_ok cancel counting with one central tracker.

Parameters:
- MAX_OUT, 2, maximum accepted-but-unanswered requests (legal range 1..3).
- CNT_W, 2, width of the outstanding count; must satisfy 2^CNT_W > MAX_OUT.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  exception or branch flush; cancels all fetch requests not yet answered.
- fetch_req_i  in  1  fetch request valid.
- fetch_addr_i  in  32  fetch virtual address.
- fetch_addr_ok_o  out  1  fetch request accepted this cycle.
- fetch_data_ok_o  out  1  fetch data valid (never asserted for a cancelled fetch).
- fetch_rdata_o  out  64  two instructions.
- cacop_req_i  in  1  maintenance request valid.
- cacop_op_i  in  5  cacop code.
- cacop_addr_i  in  32  cacop address.
- cacop_addr_ok_o  out  1  maintenance request accepted.
- cacop_done_o  out  1  maintenance completed (its data_ok returned).
- icache_req_o  out  1  request to icache.
- icache_is_cacop_o  out  1  1 = maintenance op, 0 = fetch read.
- icache_op_o  out  5  cacop code; 0 for fetch.
- icache_addr_o  out  32  request address.
- icache_addr_ok_i  in  1  icache accepted the request.
- icache_data_ok_i  in  1  icache response, in order.
- icache_rdata_i  in  64  response data.
- out_num_o  out  CNT_W  current outstanding count.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0, grant FSM in IDLE, outstanding queue empty, error cleared.

Grant FSM:
- States: IDLE, HOLD_F, HOLD_C.
- IDLE, issue decision (combinational):
  - cacop_req_i wins if out_num==0.
  - otherwise fetch_req_i wins if out_num<MAX_OUT and no cacop entry is outstanding.
  - the chosen request drives icache_req_o, icache_addr_o and icache_op_o in the same cycle.
- IDLE exits:
  - addr_ok=1 in the same cycle: accept and stay in IDLE.
  - addr_ok=0: latch addr/op into a hold register and go to HOLD_F or HOLD_C.
- HOLD_x:
  - icache_req_o=1, driven from the hold register, stable until addr_ok.
  - on addr_ok: return to IDLE.
  - requester inputs are ignored while holding.
- Flush while in HOLD_F:
  - set a hold_cancel bit; the request still completes its handshake.
  - fetch_addr_ok_o is suppressed on acceptance.
  - the entry is enqueued with cancel=1.

Accept:
- fetch_addr_ok_o = addr_ok & fetch owner & ~hold_cancel & ~flush_i.
- cacop_addr_ok_o = addr_ok & cacop owner.
- Each acceptance pushes {is_cacop, cancel} onto the queue.

Response (head of queue, on icache_data_ok_i):
- head fetch with cancel=0: fetch_data_ok_o=1 and fetch_rdata_o=icache_rdata_i in the same cycle (0 latency).
- head fetch with cancel=1: response dropped silently.
- head cacop: cacop_done_o=1.
- The head is popped in every case.

Flush:
- Sets cancel=1 on every queued fetch entry that is not being popped as valid in that cycle.
- A data_ok coinciding with flush for a non-cancelled head is dropped, i.e. flush wins.
- A fetch accepted in the flush cycle is enqueued with cancel=1.
- Cacop entries are never cancelled.

Count:
- out_num = entries in the queue; push and pop in the same cycle leave it unchanged.
- Never exceeds MAX_OUT, because issue is blocked at full.
- A pop on the same cycle as full does not enable issue in that cycle (issue gating uses the registered count).

Queue:
- Circular buffer of MAX_OUT entries; head and tail pointers wrap modulo MAX_OUT.

Errors (sticky until reset):
- data_ok with an empty queue.
- icache_addr_ok_i while icache_req_o=0.
- push while full.

Reset mid-operation:
- Queue, hold register and FSM are cleared immediately.
- The cache side is reset by the same rst_n.

Decomposition:
- Shared package/define file gets: ICACHE_OP_W=5, ICACHE_DATA_W=64, and the queue entry field layout {is_cacop, cancel}.
- One natural sub-module: icache_port_oq, the outstanding queue.
  - Operations: push/pop/flush-cancel.
  - Outputs: head fields, count, full/empty.
- FSM and routing stay in the top module.

Test Plan:
- Fetch to 0x1c000000, addr_ok same cycle, data_ok 2 cycles later with 0x0280000102800002 -> fetch_addr_ok 1 cycle, fetch_data_ok with that data, out_num 1 then 0.
- Fetch held 3 cycles without addr_ok while fetch_addr_i changes -> icache_addr_o stays at the first address until addr_ok.
- Two fetches accepted (out_num=2, third fetch blocked with icache_req_o=0), flush, then two data_ok -> no fetch_data_ok, out_num returns to 0, error_o=0.
- Cacop request while one fetch is outstanding -> not issued until that data_ok; fetch requests blocked while cacop outstanding; cacop_done_o on its data_ok.
- Flush in HOLD_F, addr_ok next cycle, then data_ok -> no fetch_addr_ok_o, no fetch_data_ok_o.
- data_ok with an empty queue -> error_o=1 next cycle and held until rst_n low.
